// File: rtl/collision_scheduler_if.sv
// Signal bundle between the collision scheduler, the bike registers, the edge detector
// and the game-state/display logic.
interface collision_scheduler_if;
  logic        frame_start;
  logic        video_on;
  logic        game_start;
  logic [18:0] bike0_loc;
  logic [2:0]  bike0_orient;
  logic [18:0] bike1_loc;
  logic [2:0]  bike1_orient;
  logic        edge_detected;
  logic [18:0] det_loc;
  logic [2:0]  det_orient;
  logic        probe_sel;
  logic        running;
  logic        crash0;
  logic        crash1;
  logic        game_over;
  logic [1:0]  winner;

  modport slave (
    input  frame_start, video_on, game_start, bike0_loc, bike0_orient, bike1_loc,
           bike1_orient, edge_detected,
    output det_loc, det_orient, probe_sel, running, crash0, crash1, game_over, winner
  );

  modport master (
    output frame_start, video_on, game_start, bike0_loc, bike0_orient, bike1_loc,
           bike1_orient, edge_detected,
    input  det_loc, det_orient, probe_sel, running, crash0, crash1, game_over, winner
  );
endinterface

// File: rtl/collision_scheduler.sv
// Time-shares one edge detector between two bikes on alternate frames, debounces hits
// and runs round state. Define OVER_TIMEOUT_EN to auto-return from OVER after OVER_FRAMES.
module collision_scheduler #(
  parameter int unsigned HIT_CONFIRM = 2,
  parameter int unsigned OVER_FRAMES = 120
) (
  input logic                  clock_i,
  input logic                  reset_i,
  collision_scheduler_if.slave bus
);

  localparam logic [2:0] HitMax = 3'(HIT_CONFIRM);

  typedef enum logic [2:0] {StIdle, StArm, StRun, StGrace, StOver} state_e;

  state_e      state_q, state_d;
  logic        probe_sel_q, probe_sel_d;
  logic [18:0] det_loc_q, det_loc_d;
  logic [2:0]  det_orient_q, det_orient_d;
  logic        hit_q, hit_d;
  logic [2:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic        crash0_q, crash0_d, crash1_q, crash1_d;
  logic [1:0]  winner_q, winner_d;

  logic       frame_hit;
  logic [2:0] cnt_sel, cnt_upd;
  logic       eval_en;

`ifdef OVER_TIMEOUT_EN
  localparam logic [6:0] OverLast = 7'(OVER_FRAMES - 1);
  logic [6:0] over_cnt_q, over_cnt_d;
`else
  logic unused_over_frames;
  assign unused_over_frames = ^7'(OVER_FRAMES);
`endif

  // A hit on the frame_start cycle still belongs to the frame that is closing.
  assign frame_hit = hit_q | (bus.edge_detected & bus.video_on);
  assign cnt_sel   = probe_sel_q ? cnt1_q : cnt0_q;
  assign cnt_upd   = !frame_hit ? 3'd0 : (cnt_sel >= HitMax) ? HitMax : cnt_sel + 3'd1;
  // A bike that already crashed is frozen during the grace frame.
  assign eval_en   = probe_sel_q ? !crash1_q : !crash0_q;

  always_comb begin
    state_d      = state_q;
    probe_sel_d  = probe_sel_q;
    det_loc_d    = det_loc_q;
    det_orient_d = det_orient_q;
    hit_d        = hit_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    crash0_d     = crash0_q;
    crash1_d     = crash1_q;
    winner_d     = winner_q;
`ifdef OVER_TIMEOUT_EN
    over_cnt_d   = over_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.game_start) begin
          state_d  = StArm;
          crash0_d = 1'b0;
          crash1_d = 1'b0;
          winner_d = 2'd0;
          cnt0_d   = 3'd0;
          cnt1_d   = 3'd0;
          hit_d    = 1'b0;
        end
      end
      StArm: begin
        if (bus.frame_start) begin
          state_d      = StRun;
          probe_sel_d  = 1'b0;
          det_loc_d    = bus.bike0_loc;
          det_orient_d = bus.bike0_orient;
        end
      end
      StRun, StGrace: begin
        hit_d = frame_hit;
        if (bus.frame_start) begin
          hit_d = 1'b0;
          if (eval_en) begin
            if (probe_sel_q) begin
              cnt1_d = cnt_upd;
              if (cnt_upd == HitMax) crash1_d = 1'b1;
            end else begin
              cnt0_d = cnt_upd;
              if (cnt_upd == HitMax) crash0_d = 1'b1;
            end
          end
          probe_sel_d  = ~probe_sel_q;
          det_loc_d    = probe_sel_q ? bus.bike0_loc : bus.bike1_loc;
          det_orient_d = probe_sel_q ? bus.bike0_orient : bus.bike1_orient;
          if (state_q == StRun) begin
            if (crash0_d || crash1_d) state_d = StGrace;
          end else begin
            state_d  = StOver;
            // {crash0, crash1}: 2 = bike1 wins, 1 = bike0 wins, 3 = draw.
            winner_d = {crash0_d, crash1_d};
          end
        end
      end
      StOver: begin
        if (bus.game_start) begin
          state_d = StIdle;
`ifdef OVER_TIMEOUT_EN
          over_cnt_d = 7'd0;
        end else if (bus.frame_start) begin
          if (over_cnt_q == OverLast) begin
            state_d    = StIdle;
            over_cnt_d = 7'd0;
          end else begin
            over_cnt_d = over_cnt_q + 7'd1;
          end
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= StIdle;
      probe_sel_q  <= 1'b0;
      det_loc_q    <= 19'd0;
      det_orient_q <= 3'd0;
      hit_q        <= 1'b0;
      cnt0_q       <= 3'd0;
      cnt1_q       <= 3'd0;
      crash0_q     <= 1'b0;
      crash1_q     <= 1'b0;
      winner_q     <= 2'd0;
`ifdef OVER_TIMEOUT_EN
      over_cnt_q   <= 7'd0;
`endif
    end else begin
      state_q      <= state_d;
      probe_sel_q  <= probe_sel_d;
      det_loc_q    <= det_loc_d;
      det_orient_q <= det_orient_d;
      hit_q        <= hit_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      crash0_q     <= crash0_d;
      crash1_q     <= crash1_d;
      winner_q     <= winner_d;
`ifdef OVER_TIMEOUT_EN
      over_cnt_q   <= over_cnt_d;
`endif
    end
  end

  assign bus.det_loc    = det_loc_q;
  assign bus.det_orient = det_orient_q;
  assign bus.probe_sel  = probe_sel_q;
  assign bus.running    = (state_q == StRun) || (state_q == StGrace);
  assign bus.crash0     = crash0_q;
  assign bus.crash1     = crash1_q;
  assign bus.game_over  = (state_q == StOver);
  assign bus.winner     = winner_q;

endmodule
